ql_episode_ctrl: RTL and testbench
==================================

# ql_episode_ctrl

Episode sequencer for the maze-solver Q-learning agent. It drives the step loop between the maze environment and the Q-learning agent. Each step runs request, environment response, one-cycle agent update, then goal/timeout check. It counts steps per episode and episodes per run, and reports completion.

## Interface

Parameters:
- STATE_W, 6, state index width (matches agent state/next_state).
- EP_W, 16, episode counter width.
- STEP_W, 8, step counter width.
- N_EPISODES, 100, episodes per training run (1..2^EP_W-1).
- MAX_STEPS, 255, step limit per episode (1..2^STEP_W-1).
- START_STATE, 0, state loaded at every episode start.
- GOAL_STATE, 63, terminal state.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  pulse; begins a run (ignored unless in IDLE).
- abort  in  1  synchronous abort; returns to IDLE from any state.
- env_valid  in  1  environment has applied the action; env_next_state is valid.
- env_next_state  in  STATE_W  state reached by the current step.
- env_req  out  1  request to environment to apply the agent's action for state_out.
- agent_en  out  1  one-cycle Q-update enable to the agent.
- state_out  out  STATE_W  current state to the agent.
- next_state_out  out  STATE_W  latched next state to the agent.
- step_cnt  out  STEP_W  completed steps in the current episode.
- episode_cnt  out  EP_W  completed episodes in the current run.
- goal_cnt  out  EP_W  episodes in the current run that ended at GOAL_STATE.
- busy  out  1  high in any state except IDLE.
- done  out  1  level; set when the run completes, cleared by the next accepted start.

## Operation

- Reset values: state IDLE; all counters 0; state_out = next_state_out = START_STATE; env_req, agent_en, busy, done = 0.
- FSM states: IDLE, INIT, REQ, UPDATE, CHECK, END_EP.
- IDLE: if start=1, clear episode_cnt, goal_cnt and done, then go to INIT.
- INIT: state_out <= START_STATE; step_cnt <= 0; go to REQ.
- REQ: env_req=1. Stay in REQ until env_valid=1. On env_valid=1, next_state_out <= env_next_state and go to UPDATE. env_valid is ignored in all other states.
- UPDATE: agent_en=1 for exactly this cycle; go to CHECK.
- CHECK:
  - step_cnt <= step_cnt+1; state_out <= next_state_out.
  - If next_state_out==GOAL_STATE, increment goal_cnt and go to END_EP.
  - Else if step_cnt+1==MAX_STEPS (timeout), go to END_EP.
  - Else go to REQ.
  - Goal takes priority when goal and timeout coincide. That episode counts in goal_cnt.
- END_EP: episode_cnt <= episode_cnt+1. If episode_cnt+1==N_EPISODES, set done=1 and go to IDLE; else go to INIT.
- abort=1 in any non-IDLE state: next state is IDLE. Counters hold their values, done stays 0, and any pending env_req/agent_en drops the next cycle. abort has priority over all other transitions. abort in IDLE has no effect.
- start while busy is ignored. start and abort together in IDLE: start wins.
- Counters never wrap, because the parameter ranges bound them.
- Asserting rst_n low mid-run forces the reset values immediately, regardless of clk.

## Timing

- All outputs are registered or decoded from the FSM state; no combinational input-to-output path.
- start accepted at edge N: INIT at N+1, env_req high from N+2.
- Step with env_valid already high on the first REQ cycle: REQ, UPDATE, CHECK = 3 cycles. Each extra REQ wait cycle adds 1 cycle.
- agent_en is high exactly 1 cycle per step, never back-to-back. state_out and next_state_out are stable during that cycle.
- Episode overhead: INIT (1 cycle) plus END_EP (1 cycle).
- done rises the cycle after END_EP of the last episode, together with busy falling.

## Test plan

- Reset: hold rst_n=0 mid-REQ with env_req=1 -> env_req=0, busy=0, all counters 0, state_out=0, asynchronously.
- Goal step: N_EPISODES=1; env returns 63 on the first REQ -> step_cnt=1, goal_cnt=1, episode_cnt=1, done=1. Exactly one agent_en pulse; busy falls 6 cycles after start.
- Timeout: MAX_STEPS=4; env always returns 5 with env_valid=1 -> 4 agent_en pulses, then INIT reloads state_out=0. goal_cnt is unchanged.
- Goal on the last allowed step: MAX_STEPS=3; env returns 1, 2, 63 -> goal_cnt increments and episode_cnt increments once.
- Handshake stall: env_valid held low 10 cycles in REQ -> env_req stays high and agent_en stays 0. An env_valid pulse outside REQ causes no state change.
- Abort/start interplay: abort in UPDATE -> IDLE next cycle with done=0. start during a run is ignored. A new start clears episode_cnt and goal_cnt.

Source files
------------

// File: rtl/ql_episode_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : ql_episode_ctrl
// Description : Episode sequencer for the maze-solver Q-learning agent.
//               Runs request / environment response / agent update / check
//               steps, counts steps, episodes and goal hits per run.
// Revision    : 1.0 - initial release
// ============================================================================
module ql_episode_ctrl #(
    parameter int STATE_W     = 6,
    parameter int EP_W        = 16,
    parameter int STEP_W      = 8,
    parameter int N_EPISODES  = 100,
    parameter int MAX_STEPS   = 255,
    parameter int START_STATE = 0,
    parameter int GOAL_STATE  = 63
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               abort,
    input  logic               env_valid,
    input  logic [STATE_W-1:0] env_next_state,
    output logic               env_req,
    output logic               agent_en,
    output logic [STATE_W-1:0] state_out,
    output logic [STATE_W-1:0] next_state_out,
    output logic [STEP_W-1:0]  step_cnt,
    output logic [EP_W-1:0]    episode_cnt,
    output logic [EP_W-1:0]    goal_cnt,
    output logic               busy,
    output logic               done
);

    localparam logic [STATE_W-1:0] C_START     = STATE_W'(START_STATE);
    localparam logic [STATE_W-1:0] C_GOAL      = STATE_W'(GOAL_STATE);
    localparam logic [STEP_W-1:0]  C_MAX_STEPS = STEP_W'(MAX_STEPS);
    localparam logic [EP_W-1:0]    C_N_EP      = EP_W'(N_EPISODES);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_INIT   = 3'd1,
        S_REQ    = 3'd2,
        S_UPDATE = 3'd3,
        S_CHECK  = 3'd4,
        S_END_EP = 3'd5
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [STATE_W-1:0] r_state_out;
    logic [STATE_W-1:0] r_next_state;
    logic [STEP_W-1:0]  r_step;
    logic [EP_W-1:0]    r_ep;
    logic [EP_W-1:0]    r_goal;
    logic               r_done;

    logic [STEP_W-1:0]  w_step_inc;
    logic [EP_W-1:0]    w_ep_inc;
    logic               w_abort;
    logic               w_at_goal;

    assign w_step_inc = r_step + 1'b1;
    assign w_ep_inc   = r_ep + 1'b1;
    assign w_abort    = abort && (r_state != S_IDLE);
    assign w_at_goal  = (r_next_state == C_GOAL);

    // Next-state decode; abort from any active state overrides everything
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (start) w_next = S_INIT;
            S_INIT:   w_next = S_REQ;
            S_REQ:    if (env_valid) w_next = S_UPDATE;
            S_UPDATE: w_next = S_CHECK;
            S_CHECK:  w_next = (w_at_goal || (w_step_inc == C_MAX_STEPS)) ? S_END_EP : S_REQ;
            S_END_EP: w_next = (w_ep_inc == C_N_EP) ? S_IDLE : S_INIT;
            default:  w_next = S_IDLE;
        endcase
        if (w_abort) begin
            w_next = S_IDLE;
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Datapath: state latches and counters; an abort cycle freezes them all
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state_out  <= C_START;
            r_next_state <= C_START;
            r_step       <= '0;
            r_ep         <= '0;
            r_goal       <= '0;
            r_done       <= 1'b0;
        end else if (!w_abort) begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_ep   <= '0;
                        r_goal <= '0;
                        r_done <= 1'b0;
                    end
                end
                S_INIT: begin
                    r_state_out <= C_START;
                    r_step      <= '0;
                end
                S_REQ: begin
                    if (env_valid) begin
                        r_next_state <= env_next_state;
                    end
                end
                S_CHECK: begin
                    r_step      <= w_step_inc;
                    r_state_out <= r_next_state;
                    if (w_at_goal) begin
                        r_goal <= r_goal + 1'b1;
                    end
                end
                S_END_EP: begin
                    r_ep <= w_ep_inc;
                    if (w_ep_inc == C_N_EP) begin
                        r_done <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign env_req        = (r_state == S_REQ);
    assign agent_en       = (r_state == S_UPDATE);
    assign busy           = (r_state != S_IDLE);
    assign done           = r_done;
    assign state_out      = r_state_out;
    assign next_state_out = r_next_state;
    assign step_cnt       = r_step;
    assign episode_cnt    = r_ep;
    assign goal_cnt       = r_goal;

endmodule
`default_nettype wire

// File: tb/tb_ql_episode_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_ql_episode_ctrl
// Description : Self-checking bench for ql_episode_ctrl. The bench plays the
//               environment and tracks expected counters with a step-level
//               episode model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ql_episode_ctrl;

    localparam int C_N_EP  = 2;
    localparam int C_MAX   = 4;
    localparam int C_START = 0;
    localparam int C_GOAL  = 63;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       env_valid = 1'b0;
    logic [5:0] env_next_state = '0;
    logic       env_req, agent_en, busy, done;
    logic [5:0] state_out, next_state_out;
    logic [7:0] step_cnt;
    logic [15:0] episode_cnt, goal_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    // Episode model: position, steps taken, finished episodes, goal hits
    int m_cur, m_step, m_ep, m_goals;
    bit m_done;

    ql_episode_ctrl #(
        .STATE_W(6), .EP_W(16), .STEP_W(8),
        .N_EPISODES(C_N_EP), .MAX_STEPS(C_MAX),
        .START_STATE(C_START), .GOAL_STATE(C_GOAL)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .env_valid(env_valid), .env_next_state(env_next_state),
        .env_req(env_req), .agent_en(agent_en),
        .state_out(state_out), .next_state_out(next_state_out),
        .step_cnt(step_cnt), .episode_cnt(episode_cnt), .goal_cnt(goal_cnt),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Accept a run from IDLE, then enter the first REQ of episode 1
    task automatic start_run(input bit with_abort);
        abort = with_abort;
        start = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        m_ep = 0; m_goals = 0; m_done = 0;
        check("start_busy", busy, 1);
        check("start_done_clr", done, 0);
        check("start_ep_clr", episode_cnt, 0);
        check("start_goal_clr", goal_cnt, 0);
        check("init_no_req", env_req, 0);
        tick();
        m_cur = C_START; m_step = 0;
        check("ep_start_state", state_out, C_START);
        check("ep_start_step", step_cnt, 0);
        check("ep_start_req", env_req, 1);
    endtask

    // One agent step from REQ: w stall cycles, then the environment answers ns
    task automatic do_step(input int ns, input int w, output bit ended);
        for (int i = 0; i < w; i++) begin
            env_valid = 1'b0;
            tick();
            check("stall_req", env_req, 1);
            check("stall_no_upd", agent_en, 0);
        end
        env_valid = 1'b1;
        env_next_state = 6'(ns);
        tick();
        env_valid = 1'b0;
        check("upd_en", agent_en, 1);
        check("upd_no_req", env_req, 0);
        check("upd_next", next_state_out, ns);
        check("upd_cur", state_out, m_cur);
        if ($urandom_range(1) == 1) begin
            env_valid = 1'b1;
            env_next_state = 6'($urandom);
        end
        tick();
        env_valid = 1'b0;
        check("chk_en_low", agent_en, 0);
        check("chk_next_hold", next_state_out, ns);
        if ($urandom_range(1) == 1) begin
            env_valid = 1'b1;
            env_next_state = 6'($urandom);
        end
        tick();
        env_valid = 1'b0;
        m_step++;
        m_cur = ns;
        ended = 0;
        if (ns == C_GOAL) begin
            m_goals++;
            ended = 1;
        end else if (m_step == C_MAX) begin
            ended = 1;
        end
        check("step_cnt", step_cnt, m_step);
        check("state_adv", state_out, m_cur);
        check("goal_cnt", goal_cnt, m_goals);
        check("req_again", env_req, !ended);
        if (ended) begin
            check("endep_busy", busy, 1);
            check("endep_ep", episode_cnt, m_ep);
        end
    endtask

    // From END_EP: either finish the run or restart into the next episode's REQ
    task automatic finish_episode();
        tick();
        m_ep++;
        check("ep_cnt", episode_cnt, m_ep);
        if (m_ep == C_N_EP) begin
            m_done = 1;
            check("run_done", done, 1);
            check("run_idle", busy, 0);
        end else begin
            check("next_init_busy", busy, 1);
            check("next_init_done", done, 0);
            tick();
            m_cur = C_START; m_step = 0;
            check("reload_state", state_out, C_START);
            check("reload_step", step_cnt, 0);
            check("reload_req", env_req, 1);
        end
    endtask

    task automatic run_steps(input int a, input int b, input int c, input int d, input int n);
        int seq[4];
        bit ended;
        seq = '{a, b, c, d};
        for (int i = 0; i < n; i++) begin
            do_step(seq[i], 0, ended);
        end
        check("seq_ended", ended, 1);
        finish_episode();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ended;
        int ns;

        // Reset values
        #3;
        check("rst_busy", busy, 0);
        check("rst_req", env_req, 0);
        check("rst_en", agent_en, 0);
        check("rst_done", done, 0);
        check("rst_state", state_out, C_START);
        check("rst_next", next_state_out, C_START);
        check("rst_ep", episode_cnt, 0);
        tick(); tick();
        rst_n = 1'b1;
        tick();

        // Directed: goal on first step, then timeout episode
        start_run(0);
        run_steps(C_GOAL, 0, 0, 0, 1);
        run_steps(5, 5, 5, 5, 4);
        check("timeout_goal_cnt", goal_cnt, 1);

        // Directed: goal on last allowed step; stall on the first step
        start_run(0);
        do_step(1, 10, ended);
        run_steps(2, 3, C_GOAL, 0, 3);
        check("last_step_goal", goal_cnt, 1);
        check("last_step_ep", episode_cnt, 1);
        run_steps(C_GOAL, 0, 0, 0, 1);

        // Done holds in IDLE; stray env_valid and abort are ignored
        env_valid = 1'b1; abort = 1'b1;
        tick(); tick();
        env_valid = 1'b0; abort = 1'b0;
        check("done_hold", done, 1);
        check("idle_hold", busy, 0);

        // Abort in UPDATE
        start_run(0);
        env_valid = 1'b1; env_next_state = 6'd9;
        tick();
        env_valid = 1'b0;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_idle", busy, 0);
        check("abort_done", done, 0);
        check("abort_en", agent_en, 0);
        check("abort_req", env_req, 0);
        check("abort_step", step_cnt, 0);

        // start+abort together in IDLE: start wins; start during run ignored
        start_run(1);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("start_ignored_req", env_req, 1);
        check("start_ignored_busy", busy, 1);
        run_steps(C_GOAL, 0, 0, 0, 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_hold_ep", episode_cnt, 1);
        check("abort_hold_goal", goal_cnt, 1);
        check("abort_hold_done", done, 0);

        // New start clears counters; then asynchronous reset mid-REQ
        start_run(0);
        run_steps(C_GOAL, 0, 0, 0, 1);
        do_step(5, 0, ended);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("arst_req", env_req, 0);
        check("arst_busy", busy, 0);
        check("arst_step", step_cnt, 0);
        check("arst_ep", episode_cnt, 0);
        check("arst_goal", goal_cnt, 0);
        check("arst_state", state_out, 0);
        check("arst_next", next_state_out, 0);
        tick();
        rst_n = 1'b1;
        tick();

        // Randomized runs against the episode model
        for (int r = 0; r < 8; r++) begin
            start_run(0);
            while (!m_done) begin
                ended = 0;
                while (!ended) begin
                    ns = ($urandom_range(3) == 0) ? C_GOAL : int'($urandom_range(62));
                    do_step(ns, int'($urandom_range(3)), ended);
                end
                finish_episode();
            end
            check("rand_goals", goal_cnt, m_goals);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
